bridge_master_pipelined: RTL and testbench

Parametrised successor to the bridge splitter. It fans one APF bridge host port out to NUM_LEAVES leaf ports, each owning a disjoint address range. Each leaf may declare a fixed read latency. Read data is captured into a holding register and stays there until the next read. Unmapped accesses are absorbed and return a default word, and requests that arrive while a read is in flight are dropped and flagged. The block sits between the Pocket core bridge and the per-peripheral register blocks.

---
 rtl/bridge_master_pipelined.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bridge_master_pipelined.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bridge_master_pipelined.sv
// ---------------------------------------------------------------------------
// bridge_master_pipelined
//   Fans one APF bridge host port out to NUM_LEAVES leaf ports, each owning a
//   disjoint inclusive address window [ADDR_FROM[i], ADDR_TO[i]]. A request
//   is latched on acceptance, strobed to its leaf one cycle later (ISSUE),
//   and for reads the leaf data is captured after RD_LATENCY[i] extra cycles
//   into a holding register that persists until the next read capture.
//   Unmapped accesses produce no strobe; unmapped reads return DEFAULT_RDATA.
//   Requests that arrive while a read is in flight are dropped.
//
//   Optional macro BRIDGE_MASTER_ERR_EN: enables a saturating 16-bit error
//   counter (unmapped accesses + dropped requests) and a sticky error flag.
//   Without it err_count/err_sticky are tied to 0.
//
// Ports
//   clk, reset            : bridge clock, synchronous active-high reset
//   bridge_endian_little  : constant ENDIAN_LITTLE
//   host_addr/wr/rd/wr_data : host request
//   host_rd_data          : held read result
//   busy                  : read in flight, new requests are dropped
//   leaf_addr/wr_data     : registered, shared by all leaves
//   leaf_wr/leaf_rd       : one-hot single-cycle strobes
//   leaf_rd_data          : per-leaf read data
//   err_count/err_sticky  : error statistics (see macro above)
// ---------------------------------------------------------------------------

// Per-leaf address window match. The unsigned offset trick folds the two
// bound compares into one and avoids constant compares when FROM is 0.
module bridge_master_pipelined_leaf #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] FROM   = '0,
  parameter logic [ADDR_W-1:0] TO     = '1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  localparam logic [ADDR_W-1:0] SPAN = TO - FROM;
  logic [ADDR_W-1:0] ofs;
  assign ofs = addr - FROM;
  assign hit = (ofs <= SPAN);
endmodule

module bridge_master_pipelined #(
  parameter logic                                ENDIAN_LITTLE = 1'b0,
  parameter int                                  NUM_LEAVES    = 2,
  parameter int                                  ADDR_W        = 32,
  parameter int                                  DATA_W        = 32,
  parameter logic [NUM_LEAVES-1:0][ADDR_W-1:0]   ADDR_FROM     = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_LEAVES-1:0][ADDR_W-1:0]   ADDR_TO       = {32'h1000_FFFF, 32'h0000_0FFF},
  parameter logic [NUM_LEAVES-1:0][3:0]          RD_LATENCY    = '0,
  parameter logic [DATA_W-1:0]                   DEFAULT_RDATA = 32'hFFFF_FFFF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 bridge_endian_little,
  input  logic [ADDR_W-1:0]                    host_addr,
  input  logic                                 host_wr,
  input  logic                                 host_rd,
  input  logic [DATA_W-1:0]                    host_wr_data,
  output logic [DATA_W-1:0]                    host_rd_data,
  output logic                                 busy,
  output logic [ADDR_W-1:0]                    leaf_addr,
  output logic [DATA_W-1:0]                    leaf_wr_data,
  output logic [NUM_LEAVES-1:0]                leaf_wr,
  output logic [NUM_LEAVES-1:0]                leaf_rd,
  input  logic [NUM_LEAVES-1:0][DATA_W-1:0]    leaf_rd_data,
  output logic [15:0]                          err_count,
  output logic                                 err_sticky
);

  localparam int SEL_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  // -------------------------------------------------------------------------
  // Static configuration checks and per-leaf decoders
  // -------------------------------------------------------------------------
  if (NUM_LEAVES < 1 || NUM_LEAVES > 16) begin : g_bad_num
    $error("bridge_master_pipelined: NUM_LEAVES must be 1..16");
  end

  logic [NUM_LEAVES-1:0] hit;

  for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
    bridge_master_pipelined_leaf #(
      .ADDR_W (ADDR_W),
      .FROM   (ADDR_FROM[i]),
      .TO     (ADDR_TO[i])
    ) u_dec (
      .addr (host_addr),
      .hit  (hit[i])
    );

    if (ADDR_TO[i] < ADDR_FROM[i]) begin : g_bad_range
      $error("bridge_master_pipelined: leaf range has to < from");
    end

    for (genvar j = i + 1; j < NUM_LEAVES; j++) begin : g_pair
      if (!((ADDR_TO[i] < ADDR_FROM[j]) || (ADDR_TO[j] < ADDR_FROM[i]))) begin : g_overlap
        $error("bridge_master_pipelined: leaf address ranges overlap");
      end
    end
  end

  // Ranges are disjoint, so at most one hit bit is set.
  logic [SEL_W-1:0] sel_now;
  logic             mapped_now;

  always_comb begin
    sel_now = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (hit[i]) sel_now = SEL_W'(i);
    end
  end

  assign mapped_now = |hit;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      leaf_addr_q, leaf_addr_d;
  logic [DATA_W-1:0]      leaf_wr_data_q, leaf_wr_data_d;
  logic [DATA_W-1:0]      host_rd_data_q, host_rd_data_d;
  logic [NUM_LEAVES-1:0]  leaf_wr_q, leaf_wr_d;
  logic [NUM_LEAVES-1:0]  leaf_rd_q, leaf_rd_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   mapped_q, mapped_d;
  logic                   is_rd_q, is_rd_d;
  logic [3:0]             cnt_q, cnt_d;

  logic       busy_int;
  logic       req;
  logic       accept;
  logic [3:0] lat_sel;

  // A write finishes in ISSUE, so only an outstanding read blocks the port.
  assign busy_int = is_rd_q && (state_q != IDLE);
  assign req      = host_wr | host_rd;
  assign accept   = req && !busy_int;
  assign lat_sel  = mapped_q ? RD_LATENCY[sel_q] : 4'd0;

  always_comb begin
    state_d        = state_q;
    leaf_addr_d    = leaf_addr_q;
    leaf_wr_data_d = leaf_wr_data_q;
    host_rd_data_d = host_rd_data_q;
    leaf_wr_d      = '0;
    leaf_rd_d      = '0;
    sel_d          = sel_q;
    mapped_d       = mapped_q;
    is_rd_d        = is_rd_q;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: ;
      ISSUE: begin
        if (is_rd_q) begin
          if (lat_sel == 4'd0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d   = lat_sel;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPTURE: begin
        host_rd_data_d = mapped_q ? leaf_rd_data[sel_q] : DEFAULT_RDATA;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is possible in IDLE and in the ISSUE cycle of a write; it
    // overrides the case above so back-to-back writes chain through ISSUE.
    // Write wins when both strobes are present.
    if (accept) begin
      leaf_addr_d    = host_addr;
      leaf_wr_data_d = host_wr_data;
      sel_d          = sel_now;
      mapped_d       = mapped_now;
      is_rd_d        = !host_wr;
      leaf_wr_d      = host_wr ? hit : '0;
      leaf_rd_d      = host_wr ? '0 : hit;
      state_d        = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      leaf_addr_q    <= '0;
      leaf_wr_data_q <= '0;
      host_rd_data_q <= '0;
      leaf_wr_q      <= '0;
      leaf_rd_q      <= '0;
      sel_q          <= '0;
      mapped_q       <= 1'b0;
      is_rd_q        <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      leaf_addr_q    <= leaf_addr_d;
      leaf_wr_data_q <= leaf_wr_data_d;
      host_rd_data_q <= host_rd_data_d;
      leaf_wr_q      <= leaf_wr_d;
      leaf_rd_q      <= leaf_rd_d;
      sel_q          <= sel_d;
      mapped_q       <= mapped_d;
      is_rd_q        <= is_rd_d;
      cnt_q          <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Error statistics
  // -------------------------------------------------------------------------
`ifdef BRIDGE_MASTER_ERR_EN
  logic [15:0] err_count_q, err_count_d;
  logic        err_sticky_q, err_sticky_d;
  logic        drop;
  logic        err_evt;

  // Dropped: anything arriving while busy, or the read half of a wr+rd pair.
  assign drop    = (req && busy_int) || (accept && host_wr && host_rd);
  assign err_evt = drop || (accept && !mapped_now);

  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q | err_evt;
    if (err_evt && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
`else
  assign err_count  = '0;
  assign err_sticky = 1'b0;
`endif

  assign bridge_endian_little = ENDIAN_LITTLE;
  assign host_rd_data         = host_rd_data_q;
  assign busy                 = busy_int;
  assign leaf_addr            = leaf_addr_q;
  assign leaf_wr_data         = leaf_wr_data_q;
  assign leaf_wr              = leaf_wr_q;
  assign leaf_rd              = leaf_rd_q;

endmodule

// File: tb/tb_bridge_master_pipelined.sv
module tb_bridge_master_pipelined;

`ifdef BRIDGE_MASTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [31:0] D0 = 32'hA5A5_0000;
  localparam logic [31:0] D1 = 32'hCAFE_0001;

  logic              clk = 1'b0;
  logic              reset;
  logic              bridge_endian_little;
  logic [31:0]       host_addr;
  logic              host_wr;
  logic              host_rd;
  logic [31:0]       host_wr_data;
  logic [31:0]       host_rd_data;
  logic              busy;
  logic [31:0]       leaf_addr;
  logic [31:0]       leaf_wr_data;
  logic [1:0]        leaf_wr;
  logic [1:0]        leaf_rd;
  logic [1:0][31:0]  leaf_rd_data;
  logic [15:0]       err_count;
  logic              err_sticky;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign leaf_rd_data = {D1, D0};

  bridge_master_pipelined #(
    .ENDIAN_LITTLE (1'b0),
    .NUM_LEAVES    (2),
    .ADDR_W        (32),
    .DATA_W        (32),
    .ADDR_FROM     ({32'h1000_0000, 32'h0000_0000}),
    .ADDR_TO       ({32'h1000_FFFF, 32'h0000_0FFF}),
    .RD_LATENCY    ({4'd3, 4'd2}),
    .DEFAULT_RDATA (32'hFFFF_FFFF)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bridge_endian_little (bridge_endian_little),
    .host_addr            (host_addr),
    .host_wr              (host_wr),
    .host_rd              (host_rd),
    .host_wr_data         (host_wr_data),
    .host_rd_data         (host_rd_data),
    .busy                 (busy),
    .leaf_addr            (leaf_addr),
    .leaf_wr_data         (leaf_wr_data),
    .leaf_wr              (leaf_wr),
    .leaf_rd              (leaf_rd),
    .leaf_rd_data         (leaf_rd_data),
    .err_count            (err_count),
    .err_sticky           (err_sticky)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; host_wr = 1'b0; host_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (leaf_wr !== 2'b00 || leaf_rd !== 2'b00) begin failures++; $display("FAIL reset_strobes got wr=%b rd=%b exp=00", leaf_wr, leaf_rd); end
    checks++; if (leaf_addr !== 32'h0 || leaf_wr_data !== 32'h0) begin failures++; $display("FAIL reset_leaf got addr=%h data=%h exp=0", leaf_addr, leaf_wr_data); end
    checks++; if (host_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", host_rd_data); end
    checks++; if (err_count !== 16'h0 || err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%h/%b exp=0/0", err_count, err_sticky); end
    checks++; if (bridge_endian_little !== 1'b0) begin failures++; $display("FAIL endian got=%b exp=0", bridge_endian_little); end
  endtask

  task automatic test_write();
    do_reset();
    @(negedge clk);
    host_addr = 32'h1000_0004; host_wr_data = 32'h1234_5678; host_wr = 1'b1;
    @(negedge clk);   // +1
    checks++; if (leaf_wr !== 2'b10) begin failures++; $display("FAIL wr_pulse got=%b exp=10", leaf_wr); end
    checks++; if (leaf_rd !== 2'b00) begin failures++; $display("FAIL wr_no_rd got=%b exp=00", leaf_rd); end
    checks++; if (leaf_addr !== 32'h1000_0004) begin failures++; $display("FAIL wr_addr got=%h exp=10000004", leaf_addr); end
    checks++; if (leaf_wr_data !== 32'h1234_5678) begin failures++; $display("FAIL wr_data got=%h exp=12345678", leaf_wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy got=%b exp=0", busy); end
    host_wr = 1'b0; host_addr = 32'h0; host_wr_data = 32'h0;
    @(negedge clk);   // +2
    checks++; if (leaf_wr !== 2'b00) begin failures++; $display("FAIL wr_single got=%b exp=00", leaf_wr); end
    checks++; if (leaf_addr !== 32'h1000_0004) begin failures++; $display("FAIL wr_addr_hold got=%h exp=10000004", leaf_addr); end
  endtask

  task automatic test_read_latency();
    do_reset();
    @(negedge clk);
    host_addr = 32'h1000_0010; host_rd = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) host_rd = 1'b0;
      checks++; if (leaf_rd !== ((k == 1) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL rd3_pulse k=%0d got=%b", k, leaf_rd); end
      checks++; if (busy !== (k <= 5)) begin failures++; $display("FAIL rd3_busy k=%0d got=%b exp=%b", k, busy, (k <= 5)); end
      checks++; if (host_rd_data !== ((k >= 6) ? D1 : 32'h0)) begin failures++; $display("FAIL rd3_data k=%0d got=%h", k, host_rd_data); end
    end
    host_addr = 32'h0000_0008; host_wr_data = 32'h0BAD_F00D; host_wr = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    checks++; if (leaf_wr !== 2'b01) begin failures++; $display("FAIL rd3_wr_after got=%b exp=01", leaf_wr); end
    @(negedge clk);
    checks++; if (host_rd_data !== D1) begin failures++; $display("FAIL rd3_held got=%h exp=%h", host_rd_data, D1); end
  endtask

  task automatic test_unmapped();
    do_reset();
    @(negedge clk);
    host_addr = 32'h2000_0000; host_rd = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) host_rd = 1'b0;
      checks++; if (leaf_rd !== 2'b00 || leaf_wr !== 2'b00) begin failures++; $display("FAIL um_strobe k=%0d got rd=%b wr=%b", k, leaf_rd, leaf_wr); end
      checks++; if (host_rd_data !== ((k == 3) ? 32'hFFFF_FFFF : 32'h0)) begin failures++; $display("FAIL um_data k=%0d got=%h", k, host_rd_data); end
    end
    checks++; if (err_count !== (ERR_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL um_errcnt got=%0d exp=%0d", err_count, ERR_EN); end
    checks++; if (err_sticky !== ERR_EN) begin failures++; $display("FAIL um_sticky got=%b exp=%b", err_sticky, ERR_EN); end
  endtask

  task automatic test_drop();
    int pulses;
    pulses = 0;
    do_reset();
    @(negedge clk);
    host_addr = 32'h0000_0010; host_rd = 1'b1;
    @(negedge clk);   // +1: keep strobe up with a new address -> dropped
    if (leaf_rd != 2'b00) pulses++;
    host_addr = 32'h0000_0020;
    @(negedge clk);   // +2
    if (leaf_rd != 2'b00) pulses++;
    host_rd = 1'b0;
    checks++; if (leaf_addr !== 32'h0000_0010) begin failures++; $display("FAIL drop_addr got=%h exp=00000010", leaf_addr); end
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      if (leaf_rd != 2'b00) pulses++;
      if (k == 5) begin
        checks++; if (host_rd_data !== D0) begin failures++; $display("FAIL drop_data got=%h exp=%h", host_rd_data, D0); end
      end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
    checks++; if (err_count !== (ERR_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL drop_errcnt got=%0d exp=%0d", err_count, ERR_EN); end
  endtask

  task automatic test_wr_rd_and_reset();
    do_reset();
    @(negedge clk);
    host_addr = 32'h0000_0040; host_wr_data = 32'h0000_0055; host_wr = 1'b1; host_rd = 1'b1;
    @(negedge clk);   // +1
    host_wr = 1'b0; host_rd = 1'b0;
    checks++; if (leaf_wr !== 2'b01 || leaf_rd !== 2'b00) begin failures++; $display("FAIL wrrd_strobe got wr=%b rd=%b exp 01/00", leaf_wr, leaf_rd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrrd_busy got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (leaf_rd !== 2'b00) begin failures++; $display("FAIL wrrd_late_rd got=%b exp=00", leaf_rd); end
    checks++; if (err_count !== (ERR_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL wrrd_errcnt got=%0d exp=%0d", err_count, ERR_EN); end
    // full read to leave a non-zero value in the holding register
    host_addr = 32'h0000_0044; host_rd = 1'b1;
    @(negedge clk); host_rd = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (host_rd_data !== D0) begin failures++; $display("FAIL pre_abort_data got=%h exp=%h", host_rd_data, D0); end
    // second read, reset during WAIT
    host_addr = 32'h0000_0048; host_rd = 1'b1;
    @(negedge clk); host_rd = 1'b0;     // +1 ISSUE
    @(negedge clk); reset = 1'b1;       // +2 WAIT
    @(negedge clk); reset = 1'b0;       // +3
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (host_rd_data !== 32'h0) begin failures++; $display("FAIL abort_data got=%h exp=0", host_rd_data); end
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      checks++; if (host_rd_data !== 32'h0 || busy !== 1'b0) begin failures++; $display("FAIL abort_nocap k=%0d got data=%h busy=%b", k, host_rd_data, busy); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    host_addr = 32'h0000_0100; host_wr_data = 32'h0000_0001; host_wr = 1'b1;
    @(negedge clk);   // +1
    checks++; if (leaf_wr !== 2'b01 || leaf_addr !== 32'h0000_0100) begin failures++; $display("FAIL b2b_first got wr=%b addr=%h", leaf_wr, leaf_addr); end
    host_addr = 32'h1000_0008; host_wr_data = 32'h0000_0002;
    @(negedge clk);   // +2
    checks++; if (leaf_wr !== 2'b10 || leaf_addr !== 32'h1000_0008 || leaf_wr_data !== 32'h2) begin failures++; $display("FAIL b2b_second got wr=%b addr=%h data=%h", leaf_wr, leaf_addr, leaf_wr_data); end
    host_addr = 32'h3000_0000; host_wr_data = 32'h0000_0003;
    @(negedge clk);   // +3 unmapped write: no strobe
    host_wr = 1'b0;
    checks++; if (leaf_wr !== 2'b00 || leaf_addr !== 32'h3000_0000) begin failures++; $display("FAIL b2b_unmapped got wr=%b addr=%h", leaf_wr, leaf_addr); end
    @(negedge clk);
    checks++; if (err_count !== (ERR_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL b2b_errcnt got=%0d exp=%0d", err_count, ERR_EN); end
    checks++; if (host_rd_data !== 32'h0) begin failures++; $display("FAIL b2b_rdata got=%h exp=0", host_rd_data); end
  endtask

  initial begin
    reset = 1'b1; host_addr = '0; host_wr = 1'b0; host_rd = 1'b0; host_wr_data = '0;
    test_reset();
    test_write();
    test_read_latency();
    test_unmapped();
    test_drop();
    test_wr_rd_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
